// File: rtl/instr_fetch_seq_pkg.sv
// instr_fetch_seq_pkg: shared CPU defaults and fetch sequencer state encoding
package instr_fetch_seq_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {ADDR_OP, CAP_OP, CAP_ARG, HOLD, DATA, DATA_CAP} state_t;
endpackage

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: two-byte instruction fetcher sharing one RAM port with execute-stage data accesses
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_we,
  output logic [DW-1:0]   ram_data,
  input  logic [DW-1:0]   ram_q,
  output logic [2*DW-1:0] instr,
  output logic [AW-1:0]   instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            jump_valid,
  input  logic [AW-1:0]   jump_addr,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_rdata,
  output logic            mem_done
);
  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pend_addr;
  logic          pend;
  logic          data_phase;

  assign data_phase = state == DATA || state == DATA_CAP;

  // RAM port steering: operand byte address wraps naturally at AW bits
  always_comb begin
    ram_addr = state == CAP_OP ? pc + AW'(1) : data_phase ? mem_addr : pc;
    ram_we   = state == DATA && mem_we;
    ram_data = mem_wdata;
  end

  // Fetch/data sequencer; redirects abort fetches at once but wait out a data access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ADDR_OP;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      mem_rdata   <= '0;
      mem_done    <= 1'b0;
      pend        <= 1'b0;
      pend_addr   <= '0;
    end else begin
      mem_done <= 1'b0;
      if (jump_valid && !data_phase) begin
        pc          <= jump_addr;
        instr_valid <= 1'b0;
        state       <= ADDR_OP;
      end else begin
        case (state)
          ADDR_OP: state <= mem_req && !mem_done ? DATA : CAP_OP;
          CAP_OP: begin
            instr[2*DW-1:DW] <= ram_q;
            state            <= CAP_ARG;
          end
          CAP_ARG: begin
            instr[DW-1:0] <= ram_q;
            instr_pc      <= pc;
            instr_valid   <= 1'b1;
            state         <= HOLD;
          end
          HOLD: if (instr_ready) begin
            pc          <= pc + AW'(2);
            instr_valid <= 1'b0;
            state       <= mem_req ? DATA : ADDR_OP;
          end
          DATA: begin
            pend      <= pend | jump_valid;
            pend_addr <= jump_valid ? jump_addr : pend_addr;
            state     <= DATA_CAP;
          end
          DATA_CAP: begin
            mem_rdata <= mem_we ? mem_rdata : ram_q;
            mem_done  <= 1'b1;
            pc        <= jump_valid ? jump_addr : pend ? pend_addr : pc;
            pend      <= 1'b0;
            state     <= ADDR_OP;
          end
          default: state <= ADDR_OP;
        endcase
      end
    end
  end
endmodule
